// File: rtl/fmul_pkg.sv
// Shared definitions for the sequential binary32 multiplier.
// Holds the operation and rounding-mode encodings, the controller state
// encoding and the fixed format constants used by fmul32_seq and fp32_round.
package fmul_pkg;

    typedef enum logic [1:0] {
        OPC_MUL  = 2'b00,   // A*B
        OPC_NMUL = 2'b01,   // -(A*B)
        OPC_ABS  = 2'b10,   // |A*B|
        OPC_SQR  = 2'b11    // A*A
    } opc_e;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,     // round to nearest, ties to even
        RM_RTZ = 2'b01,     // toward zero
        RM_RUP = 2'b10,     // toward +inf
        RM_RDN = 2'b11      // toward -inf
    } rmode_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_UNPACK   = 3'd1,
        S_MUL      = 3'd2,
        S_NORM_RND = 3'd3,
        S_DONE     = 3'd4
    } state_e;

    localparam logic [31:0] QNAN       = 32'h7FC0_0000;
    localparam int          BIAS       = 127;
    localparam int          MUL_CYCLES = 24;

endpackage

// File: rtl/fp32_round.sv
// Combinational rounding and packing stage for binary32.
// Ports:
//   sign    - sign of the final result (opc already applied)
//   exp_in  - signed 10-bit biased exponent of the normalised mantissa
//   mant    - 24-bit normalised significand (hidden bit at [23])
//   guard, rnd, sticky - bits below the significand
//   r_mode  - rounding mode (rmode_e encoding)
//   result  - packed binary32 result; flushes to signed zero below the
//             normal range, saturates to inf or max finite on overflow
module fp32_round
    import fmul_pkg::*;
(
    input  logic              sign,
    input  logic signed [9:0] exp_in,
    input  logic [23:0]       mant,
    input  logic              guard,
    input  logic              rnd,
    input  logic              sticky,
    input  logic [1:0]        r_mode,
    output logic [31:0]       result
);

    logic              inexact;
    logic              inc;
    logic              away;
    logic [24:0]       mant_sum;
    logic [22:0]       frac_fin;
    logic signed [9:0] exp_fin;

    always_comb begin
        inexact = guard | rnd | sticky;
        inc     = 1'b0;
        away    = 1'b0;
        case (rmode_e'(r_mode))
            RM_RNE: begin
                inc  = guard & (rnd | sticky | mant[0]);
                away = 1'b1;
            end
            RM_RTZ: begin
                inc  = 1'b0;
                away = 1'b0;
            end
            RM_RUP: begin
                inc  = ~sign & inexact;
                away = ~sign;
            end
            RM_RDN: begin
                inc  = sign & inexact;
                away = sign;
            end
            default: begin
                inc  = 1'b0;
                away = 1'b0;
            end
        endcase

        // A carry out of the significand means it rounded up to 2.0:
        // the fraction becomes zero and the exponent steps up by one.
        mant_sum = {1'b0, mant} + {24'd0, inc};
        if (mant_sum[24]) begin
            frac_fin = mant_sum[23:1];
            exp_fin  = exp_in + 10'sd1;
        end else begin
            frac_fin = mant_sum[22:0];
            exp_fin  = exp_in;
        end

        if (exp_fin < 10'sd1) begin
            result = {sign, 31'd0};
        end else if (exp_fin > 10'sd254) begin
            result = away ? {sign, 8'hFF, 23'd0} : {sign, 8'hFE, 23'h7F_FFFF};
        end else begin
            result = {sign, exp_fin[7:0], frac_fin};
        end
    end

endmodule

// File: rtl/fmul32_seq.sv
// Sequential IEEE-754 binary32 multiplier (shift-add, one bit per cycle).
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   start           - request, sampled only in IDLE
//   op1, op2        - binary32 operands
//   opc             - 00 A*B, 01 -(A*B), 10 |A*B|, 11 A*A
//   r_mode          - 00 RNE, 01 RTZ, 10 +inf, 11 -inf
//   busy            - high in every state except IDLE
//   result          - binary32 result, held until overwritten
//   val             - one-cycle pulse in the DONE cycle
// Handshake: a start seen high on a rising edge while IDLE captures all
// operands on that edge; start at any other time is dropped, not queued.
// val is high for exactly one cycle, and result is valid in that cycle.
module fmul32_seq
    import fmul_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [1:0]  opc,
    input  logic [1:0]  r_mode,
    output logic        busy,
    output logic [31:0] result,
    output logic        val
);

    state_e            state, state_nxt;
    logic [31:0]       a_q, b_q;
    opc_e              opc_q;
    logic [1:0]        rm_q;
    logic              sign_q;
    logic signed [9:0] exp_q;
    logic [47:0]       mcand_q;
    logic [23:0]       mplier_q;
    logic [47:0]       prod_q;
    logic [4:0]        cnt_q;
    logic [31:0]       result_q;

    // Operand classification, evaluated in UNPACK from the captured operands.
    logic [7:0]        ea, eb;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic              special;
    logic              sgn;
    logic [31:0]       special_res;
    logic signed [9:0] exp_sum;

    always_comb begin
        ea      = a_q[30:23];
        eb      = b_q[30:23];
        a_nan   = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
        b_nan   = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
        a_inf   = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
        b_inf   = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
        // Subnormals have a zero exponent field and are treated as zero.
        a_zero  = (ea == 8'h00);
        b_zero  = (eb == 8'h00);
        special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

        case (opc_q)
            OPC_MUL:  sgn = a_q[31] ^ b_q[31];
            OPC_NMUL: sgn = ~(a_q[31] ^ b_q[31]);
            default:  sgn = 1'b0;
        endcase

        if (a_nan || b_nan || ((a_inf || b_inf) && (a_zero || b_zero)))
            special_res = QNAN;
        else if (a_inf || b_inf)
            special_res = {sgn, 8'hFF, 23'd0};
        else
            special_res = {sgn, 31'd0};

        exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - $signed(10'(BIAS));
    end

    // Normalisation: the significand product lies in [1,4); bit 47 set
    // means [2,4), so take one more bit off the top and bump the exponent.
    logic signed [9:0] norm_exp;
    logic [23:0]       norm_mant;
    logic              norm_g, norm_r, norm_s;
    logic [31:0]       rnd_result;

    always_comb begin
        if (prod_q[47]) begin
            norm_mant = prod_q[47:24];
            norm_g    = prod_q[23];
            norm_r    = prod_q[22];
            norm_s    = |prod_q[21:0];
            norm_exp  = exp_q + 10'sd1;
        end else begin
            norm_mant = prod_q[46:23];
            norm_g    = prod_q[22];
            norm_r    = prod_q[21];
            norm_s    = |prod_q[20:0];
            norm_exp  = exp_q;
        end
    end

    fp32_round u_round (
        .sign   (sign_q),
        .exp_in (norm_exp),
        .mant   (norm_mant),
        .guard  (norm_g),
        .rnd    (norm_r),
        .sticky (norm_s),
        .r_mode (rm_q),
        .result (rnd_result)
    );

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Controller next-state and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        val       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_UNPACK;
            end
            S_UNPACK:   state_nxt = special ? S_DONE : S_MUL;
            S_MUL:      if (cnt_q == 5'(MUL_CYCLES - 1)) state_nxt = S_NORM_RND;
            S_NORM_RND: state_nxt = S_DONE;
            S_DONE: begin
                val       = 1'b1;
                state_nxt = S_IDLE;
            end
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            opc_q    <= OPC_MUL;
            rm_q     <= 2'd0;
            sign_q   <= 1'b0;
            exp_q    <= 10'sd0;
            mcand_q  <= 48'd0;
            mplier_q <= 24'd0;
            prod_q   <= 48'd0;
            cnt_q    <= 5'd0;
            result_q <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= op1;
                        // Squaring reuses the product path with B taken from A.
                        b_q   <= (opc == OPC_SQR) ? op1 : op2;
                        opc_q <= opc_e'(opc);
                        rm_q  <= r_mode;
                    end
                end
                S_UNPACK: begin
                    sign_q   <= sgn;
                    exp_q    <= exp_sum;
                    mcand_q  <= {24'd0, 1'b1, a_q[22:0]};
                    mplier_q <= {1'b1, b_q[22:0]};
                    prod_q   <= 48'd0;
                    cnt_q    <= 5'd0;
                    if (special) result_q <= special_res;
                end
                S_MUL: begin
                    if (mplier_q[0]) prod_q <= prod_q + mcand_q;
                    mcand_q  <= {mcand_q[46:0], 1'b0};
                    mplier_q <= {1'b0, mplier_q[23:1]};
                    cnt_q    <= cnt_q + 5'd1;
                end
                S_NORM_RND: result_q <= rnd_result;
                default: ;
            endcase
        end
    end

    assign result = result_q;

endmodule

// File: doc/fmul32_seq.md
FMUL32_SEQ -- requirements
Module: fmul32_seq

Interface
REQ-001 Parameter: none; the format is fixed at IEEE-754 binary32.
REQ-002 clk     input   1   single clock; all state updates on the rising edge.
REQ-003 rst_n   input   1   asynchronous, active-low reset.
REQ-004 start   input   1   request; accepted only in IDLE.
REQ-005 op1     input   32  operand A, binary32.
REQ-006 op2     input   32  operand B, binary32.
REQ-007 opc     input   2   operation: 00 A*B, 01 -(A*B), 10 |A*B|, 11 A*A.
REQ-008 r_mode  input   2   rounding: 00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf.
REQ-009 busy    output  1   high in every state except IDLE.
REQ-010 result  output  32  binary32 result, held until the next accepted start.
REQ-011 val     output  1   one-cycle pulse when result becomes valid.

Function
REQ-012 op1, op2, opc and r_mode shall be registered in the cycle start is accepted (T); later input changes shall have no effect.
REQ-013 The FSM shall have states IDLE, UNPACK, MUL, NORM_RND and DONE; IDLE->UNPACK on start; UNPACK->DONE for special operands, else UNPACK->MUL; MUL shall last 24 cycles; MUL->NORM_RND; NORM_RND->DONE; DONE->IDLE.
REQ-014 val shall be high exactly during the DONE cycle, which is T+2 for special operands and T+27 for finite non-zero operands.
REQ-015 start while busy shall be ignored and shall not be queued.
REQ-016 start asserted in the DONE cycle shall be ignored; start in the following IDLE cycle shall be accepted.
REQ-017 The mantissa product shall be formed by iterative shift-add of the 24-bit significands, one bit per MUL cycle, into a 48-bit product.
REQ-018 Exponent arithmetic: sum = eA + eB - 127, computed 10-bit signed.
REQ-019 Normalisation: a product in [2,4) shall be shifted right by one with exponent +1; guard, round and sticky bits shall be kept.
REQ-020 Rounding shall follow r_mode using the sign of the final result.
REQ-021 Subnormal inputs shall be treated as zero of the same sign.
REQ-022 A result exponent below 1 after rounding shall flush to signed zero.
REQ-023 Overflow shall return signed infinity for RNE, and for a rounding direction that points away from zero; otherwise it shall return the signed maximum finite value 7F7FFFFF/FF7FFFFF.
REQ-024 Any NaN input, or 0*Inf, shall return the canonical quiet NaN 7FC00000 regardless of opc.
REQ-025 Inf*finite-nonzero shall return signed infinity; zero*finite shall return signed zero.
REQ-026 Sign rules: opc 00 uses sA^sB; opc 01 inverts that sign; opc 10 forces 0; opc 11 forces 0 with B:=A.

Reset
REQ-027 rst_n low shall asynchronously force state to IDLE, with result=32'h0, val=0 and busy=0.
REQ-028 rst_n low mid-operation shall abort the operation with no val pulse; the first start accepted after release shall behave as from cold reset.

Structure
REQ-029 A shared package fmul_pkg shall hold the opc and r_mode enums, the FSM state enum, and the constants QNAN=7FC00000, BIAS=127 and MUL_CYCLES=24.
REQ-030 Rounding and overflow selection shall live in one combinational sub-module, fp32_round, taking sign, 10-bit exponent, 24-bit mantissa, guard/round/sticky and r_mode, and producing the packed 32-bit result.

Verification
REQ-031 Basic multiply: 3F800000 * 40000000, opc=00, RNE -> result 40000000, val at T+27; the same operands with opc=01 -> C0000000.
REQ-032 Square: op1=C0400000, opc=11 -> 41100000.
REQ-033 Special operands: 7F800000 * 00000000 -> 7FC00000 at T+2; FF800000 * 40000000 -> FF800000 at T+2.
REQ-034 Rounding: 3F800001 * 3F800001 -> 3F800002 for RNE and RTZ, 3F800003 for toward +inf; 7F7FFFFF * 40000000 -> 7F800000 for RNE, 7F7FFFFF for RTZ.
REQ-035 Underflow: 00800000 * 3F000000 -> 00000000; 80800000 * 3F000000 -> 80000000.
REQ-036 Protocol: start pulsed at T+5 during busy -> ignored, with exactly one val; rst_n low at T+10 -> no val, result 0; a new start after release -> correct result at T'+27.
